// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type and default frame constants
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLING = 8;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with selectable reset value
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of an asynchronous input into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with framing-error and break handling
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLING = DEFAULT_OVERSAMPLING,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rxd,
  output logic                 baud_enable,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLING);
  localparam int BIT_W = $clog2(DATA_BITS);

  // tick count values at which the start bit (middle) and data/stop bits are sampled
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLING - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  uart_state_t          state;
  uart_state_t          state_next;
  logic                 rxs;
  logic [CNT_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 accept;
  logic                 mid_tick;
  logic                 full_tick;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  // ticks only count while the generator is enabled by this receiver
  assign accept    = tick & baud_enable;
  assign mid_tick  = accept && (tick_cnt == MID_CNT);
  assign full_tick = accept && (tick_cnt == LAST_CNT);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state selection from the synchronized line and sample points
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rxs) state_next = START;
      START:   if (mid_tick) state_next = rxs ? IDLE : DATA;
      DATA:    if (full_tick && (bit_cnt == LAST_BIT)) state_next = STOP;
      STOP:    if (full_tick) state_next = rxs ? IDLE : BREAK;
      BREAK:   if (rxs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // state-decoded outputs; the generator runs only while a frame is being timed
  always_comb begin
    baud_enable = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE:              busy = 1'b0;
      START, DATA, STOP: baud_enable = 1'b1;
      default:           baud_enable = 1'b0;
    endcase
  end

  // counters, shift register and one-cycle result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        START: begin
          if (mid_tick) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end else if (accept) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (accept) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
          if (full_tick) begin
            shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (accept) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
          if (full_tick) begin
            if (rxs) begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end
        end
        default: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  localparam int OS       = 8;
  localparam int TICK_DIV = 4;
  localparam int BIT      = OS * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       rxd;
  logic       baud_enable;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  uart_rx #(
    .OVERSAMPLING (OS),
    .DATA_BITS    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .rxd         (rxd),
    .baud_enable (baud_enable),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // free-running oversample tick, one clk wide every TICK_DIV clocks
  initial begin
    tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  typedef struct {
    bit         err;
    logic [7:0] data;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];
  int  nv        = 0;
  int  nf        = 0;
  int  bad_pulse = 0;
  logic prev_dv  = 1'b0;
  logic prev_fe  = 1'b0;

  // records every result pulse and flags overlapping or stretched pulses
  always @(negedge clk) begin
    if (data_valid) begin
      nv <= nv + 1;
      got_q.push_back('{1'b0, data_out});
    end
    if (frame_error) begin
      nf <= nf + 1;
      got_q.push_back('{1'b1, 8'h00});
    end
    if ((data_valid && frame_error) || (data_valid && prev_dv) || (frame_error && prev_fe))
      bad_pulse <= bad_pulse + 1;
    prev_dv <= data_valid;
    prev_fe <= frame_error;
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int stop_bits);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (BIT * stop_bits) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         stop_bits;
    int         idle_bits;
    int         exp_nv;
    int         exp_nf;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] model_dout;
  int         nv0;
  int         nf0;
  int         viol;
  int         base;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 2, 1, 0, 8'hA5};
    vecs[1] = '{8'hC3, 1'b0, 3, 2, 0, 1, 8'hA5};
    vecs[2] = '{8'h01, 1'b1, 1, 1, 1, 0, 8'h01};
    vecs[3] = '{8'h80, 1'b1, 1, 0, 1, 0, 8'h80};
    vecs[4] = '{8'h5A, 1'b0, 1, 2, 0, 1, 8'h80};
    vecs[5] = '{8'h81, 1'b1, 1, 1, 1, 0, 8'h81};

    // reset holds everything idle even with the line low
    rst = 1'b1;
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_baud", {31'd0, baud_enable}, 32'd0);
    check("rst_dout", {24'd0, data_out}, 32'd0);
    check("rst_dv", {31'd0, data_valid}, 32'd0);
    check("rst_fe", {31'd0, frame_error}, 32'd0);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_dout = 8'h00;

    // ticks in IDLE with a high line change nothing
    nv0 = nv;
    nf0 = nf;
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy || baud_enable || data_out != 8'h00) viol++;
    end
    check("idle_ticks_viol", viol, 0);
    check("idle_ticks_pulses", (nv - nv0) + (nf - nf0), 0);

    // short low glitch: start detected 3 cycles later, then aborted
    nv0 = nv;
    nf0 = nf;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    check("fs_busy_lat2", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("fs_busy_lat3", {31'd0, busy}, 32'd1);
    check("fs_baud_on", {31'd0, baud_enable}, 32'd1);
    repeat (2 * TICK_DIV - 3) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("fs_busy_off", {31'd0, busy}, 32'd0);
    check("fs_baud_off", {31'd0, baud_enable}, 32'd0);
    check("fs_pulses", (nv - nv0) + (nf - nf0), 0);

    // table of single frames
    for (int i = 0; i < 6; i++) begin
      nv0 = nv;
      nf0 = nf;
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].stop_bits);
      repeat (BIT * vecs[i].idle_bits) @(negedge clk);
      wait_idle($sformatf("vec%0d_idle", i));
      check($sformatf("vec%0d_nv", i), nv - nv0, vecs[i].exp_nv);
      check($sformatf("vec%0d_nf", i), nf - nf0, vecs[i].exp_nf);
      check($sformatf("vec%0d_dout", i), {24'd0, data_out}, {24'd0, vecs[i].exp_dout});
    end
    model_dout = 8'h81;

    // back-to-back frames with single stop bits
    nv0 = nv;
    nf0 = nf;
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    repeat (BIT) @(negedge clk);
    wait_idle("b2b_idle");
    check("b2b_nv", nv - nv0, 2);
    check("b2b_nf", nf - nf0, 0);
    if (got_q.size() >= 2) begin
      check("b2b_first", {24'd0, got_q[got_q.size()-2].data}, 32'h00);
      check("b2b_second", {24'd0, got_q[got_q.size()-1].data}, 32'hFF);
    end else begin
      check("b2b_qsize", got_q.size(), 2);
    end
    check("b2b_dout", {24'd0, data_out}, 32'hFF);
    model_dout = 8'hFF;

    // long break after a frame: one error pulse, busy until the line rises
    nv0 = nv;
    nf0 = nf;
    send_frame(8'h3C, 1'b0, 10);
    rxd = 1'b0;
    check("brk_busy_mid", {31'd0, busy}, 32'd1);
    check("brk_baud_mid", {31'd0, baud_enable}, 32'd0);
    repeat (BIT * 10) @(negedge clk);
    check("brk_busy_late", {31'd0, busy}, 32'd1);
    check("brk_nf_once", nf - nf0, 1);
    rxd = 1'b1;
    wait_idle("brk_idle");
    check("brk_nv", nv - nv0, 0);
    check("brk_dout", {24'd0, data_out}, {24'd0, model_dout});

    // reset during bit 4 aborts silently, next frame still received
    nv0 = nv;
    nf0 = nf;
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = (8'h5A >> i) & 1'b1;
      repeat (BIT) @(negedge clk);
    end
    rxd = (8'h5A >> 4) & 1'b1;
    repeat (BIT / 2) @(negedge clk);
    check("mrst_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_baud", {31'd0, baud_enable}, 32'd0);
    check("mrst_dout", {24'd0, data_out}, 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (BIT * 2) @(negedge clk);
    check("mrst_pulses", (nv - nv0) + (nf - nf0), 0);
    send_frame(8'h81, 1'b1, 1);
    wait_idle("mrst_idle");
    check("mrst_next_nv", nv - nv0, 1);
    check("mrst_next_dout", {24'd0, data_out}, 32'h81);
    model_dout = 8'h81;

    // randomized frames against an event-level model
    base = got_q.size();
    for (int f = 0; f < 40; f++) begin
      logic [7:0] d;
      bit         ok;
      int         gap;
      d  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(d, ok, ok ? 1 : int'($urandom_range(1, 3)));
      if (ok) begin
        exp_q.push_back('{1'b0, d});
        model_dout = d;
        gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 2 * BIT));
      end else begin
        exp_q.push_back('{1'b1, 8'h00});
        gap = BIT + int'($urandom_range(0, BIT));
      end
      repeat (gap) @(negedge clk);
    end
    repeat (BIT) @(negedge clk);
    wait_idle("rnd_idle");
    check("rnd_count", got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) begin
        check($sformatf("rnd%0d_kind", i), {31'd0, got_q[base+i].err}, {31'd0, exp_q[i].err});
        if (!exp_q[i].err)
          check($sformatf("rnd%0d_data", i), {24'd0, got_q[base+i].data}, {24'd0, exp_q[i].data});
      end
    end
    check("rnd_dout", {24'd0, data_out}, {24'd0, model_dout});

    check("pulse_shape", bad_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter OVERSAMPLING, default 8, giving ticks per bit; legal values are powers of two, 4 or more.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal range is 5 to 9.
REQ-003 clk  input  1  Single clock; all logic on posedge clk.
REQ-004 rst  input  1  Synchronous reset, active-high.
REQ-005 tick  input  1  Oversample tick from the upstream baud tick generator; one-cycle pulse at Baud*OVERSAMPLING.
REQ-006 rxd  input  1  Asynchronous serial line; idle-high.
REQ-007 baud_enable  output  1  Drives the generator's enable input; low re-phases the generator.
REQ-008 data_out  output  DATA_BITS  Last good received word.
REQ-009 data_valid  output  1  One-cycle pulse when data_out updates.
REQ-010 frame_error  output  1  One-cycle pulse when the stop bit is sampled low.
REQ-011 busy  output  1  High in every state except IDLE.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rxs, which lags rxd by 2 cycles.
REQ-013 States SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-014 A tick counter, log2(OVERSAMPLING) bits wide, and a bit counter SHALL advance only on cycles where tick=1 and baud_enable=1; ticks outside that condition SHALL be ignored.
REQ-015 IDLE: baud_enable=0 and counters cleared; when rxs=0, go to START and set baud_enable=1 on the next cycle.
REQ-016 START: on the (OVERSAMPLING/2)th accepted tick, sample rxs:
- rxs=0: clear the tick counter and go to DATA.
- rxs=1: false start; return to IDLE with no output pulse.
REQ-017 DATA: on every OVERSAMPLINGth accepted tick, shift rxs into the shift register LSB-first; after DATA_BITS samples, go to STOP.
REQ-018 STOP: on the OVERSAMPLINGth accepted tick, sample rxs:
- rxs=1: the next cycle loads data_out from the shift register, pulses data_valid, and goes to IDLE.
- rxs=0: the next cycle pulses frame_error, leaves data_out unchanged, and goes to BREAK.
REQ-019 BREAK: baud_enable=0; stay in BREAK until rxs=1, then go to IDLE.
REQ-020 data_valid and frame_error SHALL never assert in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-021 There is no backpressure; a new frame SHALL overwrite data_out regardless of whether the previous word was consumed.
REQ-022 A start edge arriving in the same cycle as the return to IDLE SHALL be detected on the following cycle, so back-to-back frames with a single stop bit are received without loss.
REQ-023 The tick counter SHALL wrap to 0 at OVERSAMPLING; the bit counter SHALL reset when entering DATA.

Reset
REQ-024 While rst=1, the block SHALL hold: state=IDLE, both synchronizer flops=1, data_out=0, shift register=0, counters=0, data_valid=0, frame_error=0, baud_enable=0, busy=0.
REQ-025 rst asserted mid-frame SHALL abort the frame with no data_valid or frame_error pulse; reception resumes from IDLE on the first cycle after rst deasserts.

Structure
REQ-026 Package uart_pkg SHALL hold the state enumeration and the default OVERSAMPLING and DATA_BITS constants, shared with the tick generator and a future transmitter.
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module named sync_2ff with a reset-value parameter; everything else is flat in uart_rx.

Verification
REQ-028 Scenario: OVERSAMPLING=8, tick every 4 clk, frame 0xA5 with a valid stop bit -> exactly one data_valid pulse, data_out=0xA5, frame_error never asserted.
REQ-029 Scenario: rxd low for 2 tick periods, then high -> START aborts to IDLE, baud_enable returns to 0, no output pulses.
REQ-030 Scenario: frame 0x3C with the stop bit held low for 20 bit times -> frame_error pulses once, data_out keeps its previous value, busy stays high until rxd returns high.
REQ-031 Scenario: back-to-back frames 0x00 then 0xFF with one stop bit each -> two data_valid pulses, in order, with correct data.
REQ-032 Scenario: rst asserted during bit 4 of frame 0x5A -> all outputs at reset values; the next frame 0x81 is received correctly.
REQ-033 Scenario: tick pulses while in IDLE with rxd high -> state, counters and outputs unchanged.
